hazard_forward_unit: RTL and testbench

Tracks the destination registers of the instructions in the EXE, MEM and WB stages of the 5-stage MIPS pipeline. Drives the operand-select lines that the EXE stage's forwarding muxes consume: 0 = register-file value, 1 = MEM-stage result, 2 = WB-stage value. Detects load-use and (with forwarding disabled) RAW hazards and stalls IF/ID. Sits beside ID/EX, fed by the decoder, with a branch-flush input from EXE.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/hazard_forward_unit_fwd_select.sv | 22 ++
 rtl/hazard_forward_unit.sv | 94 +++++++++
 tb/tb_hazard_forward_unit.sv | 115 +++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: forward-select encodings and the per-stage
// destination-tracking entry used by the hazard/forwarding unit.
package mips_pkg;
  localparam int RIDX_W = 5;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef struct packed {
    logic              valid;
    logic [RIDX_W-1:0] dest;
    logic              wb_en;
    logic              mem_read;
  } entry_t;

  localparam entry_t ENTRY_BUBBLE = '0;

  // $0 is hardwired, so a write to it never creates a dependency.
  function automatic logic ent_match(entry_t e, logic [RIDX_W-1:0] s);
    return e.valid && e.wb_en && (e.dest == s) && (s != '0);
  endfunction
endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Forward-select for one ID source: youngest in-flight writer wins.
module fwd_select
  import mips_pkg::*;
#(
  parameter int SEL_W = 2
) (
  input  logic [RIDX_W-1:0] src,
  input  entry_t            ex_e,
  input  entry_t            mem_e,
  input  logic              fwd_en,
  output logic [SEL_W-1:0]  sel
);

  always_comb begin
    sel = SEL_W'(FWD_REG);
    if (fwd_en) begin
      if (ent_match(ex_e, src))       sel = SEL_W'(FWD_MEM);
      else if (ent_match(mem_e, src)) sel = SEL_W'(FWD_WB);
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Tracks EXE/MEM/WB destinations, drives registered EXE forward selects and
// a combinational IF/ID stall for load-use (or all RAW when forwarding is off).
module hazard_forward_unit
  import mips_pkg::*;
#(
  parameter int REG_W = RIDX_W,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_en,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_src2_used,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_read,
  input  logic             br_taken,
  output logic [SEL_W-1:0] sel_val1,
  output logic [SEL_W-1:0] sel_val2,
  output logic [SEL_W-1:0] sel_src2,
  output logic             hazard_stall,
  output logic [31:0]      stall_count
);

  entry_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [SEL_W-1:0] sel_val1_q, sel_val1_d, sel_val2_q, sel_val2_d;
  logic [SEL_W-1:0] sel_src2_q, sel_src2_d;
  logic [31:0]      stall_count_q, stall_count_d;

  logic [SEL_W-1:0] f_val1, f_val2, f_src2;
  logic             m_ex1, m_ex2, m_mem1, m_mem2, raw_hz, load_ex;

  fwd_select #(.SEL_W(SEL_W)) u_sel_val1 (
    .src(id_src1), .ex_e(ex_q), .mem_e(mem_q), .fwd_en(fwd_en), .sel(f_val1));
  fwd_select #(.SEL_W(SEL_W)) u_sel_val2 (
    .src(id_src2), .ex_e(ex_q), .mem_e(mem_q), .fwd_en(fwd_en), .sel(f_val2));
  fwd_select #(.SEL_W(SEL_W)) u_sel_src2 (
    .src(id_src2), .ex_e(ex_q), .mem_e(mem_q), .fwd_en(fwd_en), .sel(f_src2));

  always_comb begin
    m_ex1  = ent_match(ex_q, id_src1);
    m_ex2  = id_src2_used && ent_match(ex_q, id_src2);
    m_mem1 = ent_match(mem_q, id_src1);
    m_mem2 = id_src2_used && ent_match(mem_q, id_src2);
    // With forwarding only a load in EXE is too late; without it any writer in EXE/MEM is.
    if (fwd_en) raw_hz = ex_q.mem_read && (m_ex1 || m_ex2);
    else        raw_hz = m_ex1 || m_ex2 || m_mem1 || m_mem2;
    hazard_stall = id_valid && !br_taken && raw_hz;
    load_ex      = id_valid && !hazard_stall && !br_taken;

    ex_d = ENTRY_BUBBLE;
    if (load_ex) begin
      ex_d.valid    = 1'b1;
      ex_d.dest     = id_dest;
      ex_d.wb_en    = id_wb_en;
      ex_d.mem_read = id_mem_read;
    end
    mem_d = ex_q;
    wb_d  = mem_q;

    sel_val1_d = load_ex ? f_val1 : '0;
    sel_val2_d = (load_ex && id_src2_used) ? f_val2 : '0;
    sel_src2_d = (load_ex && id_src2_used) ? f_src2 : '0;
    stall_count_d = stall_count_q + 32'(hazard_stall);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q          <= ENTRY_BUBBLE;
      mem_q         <= ENTRY_BUBBLE;
      wb_q          <= ENTRY_BUBBLE;
      sel_val1_q    <= '0;
      sel_val2_q    <= '0;
      sel_src2_q    <= '0;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      sel_val1_q    <= sel_val1_d;
      sel_val2_q    <= sel_val2_d;
      sel_src2_q    <= sel_src2_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign sel_val1    = sel_val1_q;
  assign sel_val2    = sel_val2_q;
  assign sel_src2    = sel_src2_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench: each step drives ID, checks the combinational stall, and
// queues the selects/count expected after the edge for the scoreboard.
module tb_hazard_forward_unit;
  logic        clk = 1'b0;
  logic        rst, fwd_en, id_valid, id_src2_used, id_wb_en, id_mem_read, br_taken;
  logic [4:0]  id_src1, id_src2, id_dest;
  logic [1:0]  sel_val1, sel_val2, sel_src2;
  logic        hazard_stall;
  logic [31:0] stall_count;

  typedef struct {
    logic [1:0]  s1, s2, ss;
    logic [31:0] cnt;
    string       tag;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_forward_unit dut (
    .clk(clk), .rst(rst), .fwd_en(fwd_en), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2), .id_src2_used(id_src2_used),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .br_taken(br_taken), .sel_val1(sel_val1), .sel_val2(sel_val2),
    .sel_src2(sel_src2), .hazard_stall(hazard_stall), .stall_count(stall_count));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pipeline cycle: r=rst, v/s1/s2/u/d/w/m = ID fields, b=br_taken.
  task automatic cyc(input string tag, input logic r, input logic v,
                     input int s1, input int s2, input logic u, input int d,
                     input logic w, input logic m, input logic b,
                     input logic e_stall, input logic [1:0] e1, input logic [1:0] e2,
                     input logic [1:0] es, input int e_cnt);
    exp_t e, got;
    @(negedge clk);
    rst = r; id_valid = v; id_src1 = 5'(s1); id_src2 = 5'(s2); id_src2_used = u;
    id_dest = 5'(d); id_wb_en = w; id_mem_read = m; br_taken = b;
    #1;
    chk({tag, ".stall"}, 32'(hazard_stall), 32'(e_stall));
    e.s1 = e1; e.s2 = e2; e.ss = es; e.cnt = 32'(e_cnt); e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({got.tag, ".sel_val1"}, 32'(sel_val1), 32'(got.s1));
    chk({got.tag, ".sel_val2"}, 32'(sel_val2), 32'(got.s2));
    chk({got.tag, ".sel_src2"}, 32'(sel_src2), 32'(got.ss));
    chk({got.tag, ".count"}, stall_count, got.cnt);
  endtask

  initial begin
    fwd_en = 1'b1;
    //   tag        r  v  s1 s2 u  d  w  m  b   stall s1 s2 ss cnt
    cyc("reset0",   0, 0, 0, 0, 0, 0, 0, 0, 0,  0,    0, 0, 0, 0);
    cyc("reset1",   0, 0, 0, 0, 0, 0, 0, 0, 0,  0,    0, 0, 0, 0);
    // add $3 ; sub $4,$3,$5 -> EXE->MEM forward on operand 1
    cyc("add3",     1, 1, 1, 2, 1, 3, 1, 0, 0,  0,    0, 0, 0, 0);
    cyc("sub_fwd",  1, 1, 3, 5, 1, 4, 1, 0, 0,  0,    1, 0, 0, 0);
    // add $3 ; nop ; or $6,$7,$3 -> WB forward on operand 2
    cyc("add3b",    1, 1, 1, 1, 1, 3, 1, 0, 0,  0,    0, 0, 0, 0);
    cyc("nop",      1, 0, 0, 0, 0, 0, 0, 0, 0,  0,    0, 0, 0, 0);
    cyc("or_wb",    1, 1, 7, 3, 1, 6, 1, 0, 0,  0,    0, 2, 2, 0);
    // $3 in both ex and mem -> youngest (ex) wins
    cyc("add3c",    1, 1, 1, 1, 1, 3, 1, 0, 0,  0,    0, 0, 0, 0);
    cyc("add3d",    1, 1, 1, 1, 1, 3, 1, 0, 0,  0,    0, 0, 0, 0);
    cyc("prio",     1, 1, 3, 3, 1, 9, 1, 0, 0,  0,    1, 1, 1, 0);
    // lw $2 ; add $8,$2,$2 -> one stall, then WB forward
    cyc("lw2",      1, 1, 1, 0, 0, 2, 1, 1, 0,  0,    0, 0, 0, 0);
    cyc("lu_stall", 1, 1, 2, 2, 1, 8, 1, 0, 0,  1,    0, 0, 0, 1);
    cyc("lu_go",    1, 1, 2, 2, 1, 8, 1, 0, 0,  0,    2, 2, 2, 1);
    // forwarding off: RAW stalls until the writer reaches WB
    fwd_en = 1'b0;
    cyc("nf_add3",  1, 1, 1, 1, 1, 3, 1, 0, 0,  0,    0, 0, 0, 1);
    cyc("nf_st1",   1, 1, 3, 5, 1, 4, 1, 0, 0,  1,    0, 0, 0, 2);
    cyc("nf_st2",   1, 1, 3, 5, 1, 4, 1, 0, 0,  1,    0, 0, 0, 3);
    cyc("nf_go",    1, 1, 3, 5, 1, 4, 1, 0, 0,  0,    0, 0, 0, 3);
    fwd_en = 1'b1;
    // writers of $0 never create dependencies
    cyc("add0",     1, 1, 1, 1, 1, 0, 1, 0, 0,  0,    0, 0, 0, 3);
    cyc("rd0",      1, 1, 0, 0, 1, 5, 1, 0, 0,  0,    0, 0, 0, 3);
    cyc("lw0",      1, 1, 1, 0, 0, 0, 1, 1, 0,  0,    0, 0, 0, 3);
    cyc("rd0_lw",   1, 1, 0, 0, 1, 7, 1, 0, 0,  0,    0, 0, 0, 3);
    // sw store data from the prior add; selects gated by src2_used
    cyc("add3e",    1, 1, 1, 1, 1, 3, 1, 0, 0,  0,    0, 0, 0, 3);
    cyc("sw_used",  1, 1, 1, 3, 1, 0, 0, 0, 0,  0,    0, 1, 1, 3);
    cyc("sw_unused",1, 1, 1, 3, 0, 0, 0, 0, 0,  0,    0, 0, 0, 3);
    // load-use coinciding with a taken branch: flush wins
    cyc("lw2b",     1, 1, 1, 0, 0, 2, 1, 1, 0,  0,    0, 0, 0, 3);
    cyc("br_flush", 1, 1, 2, 2, 1, 8, 1, 0, 1,  0,    0, 0, 0, 3);
    cyc("post_br",  1, 1, 2, 2, 1, 8, 1, 0, 0,  0,    2, 2, 2, 3);
    // reset mid-stream with a pending load-use
    cyc("lw2c",     1, 1, 1, 0, 0, 2, 1, 1, 0,  0,    0, 0, 0, 3);
    cyc("mid_rst",  0, 1, 2, 2, 1, 8, 1, 0, 0,  1,    0, 0, 0, 0);
    cyc("after_rst",1, 1, 2, 2, 1, 8, 1, 0, 0,  0,    0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
